// File: rtl/arc_mem_pkg.sv
// Shared definitions for the ARC memory access unit: bus widths, word size,
// the transaction FSM state encoding and the reset values of every output.
package arc_mem_pkg;

    // Default bus widths; the top exposes them as overridable parameters.
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Bytes per memory word and the number of low address bits that must be
    // zero for a word-aligned access.
    localparam int WORD_BYTES = 4;
    localparam int ALIGN_BITS = $clog2(WORD_BYTES);

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Values every register returns to on reset.
    localparam state_e RST_STATE  = IDLE;
    localparam logic   RST_STROBE = 1'b0;
    localparam logic   RST_ERR    = 1'b0;

    // A request address is misaligned when any byte-offset bit is set.
    function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational word-alignment check on the byte-offset bits of a request
// address. Only present in builds with the alignment check enabled.
module mem_align_chk
    import arc_mem_pkg::*;
(
    input  logic [ALIGN_BITS-1:0] i_addr_lsb,
    output logic                  o_misaligned
);

    // Flag any access whose byte offset within the word is non-zero.
    always_comb begin
        o_misaligned = is_misaligned(i_addr_lsb);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Bus initiator between the ARC control unit and main memory.
//
// One load/store/fetch is in flight at a time. The sequencer walks
// IDLE -> ISSUE -> (CAPTURE ->) RESP -> IDLE; all memory strobes, the
// address/data bus and the response payload are registered so the memory
// port never sees a combinational glitch.
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both high. The request channel is only ready in
// IDLE, so a request arriving while busy waits. The response is held stable
// in RESP until rsp_ready is sampled high.
//
// Build option: define ALIGN_CHECK_EN to reject accesses with a non-zero
// byte offset (no strobe, error response one cycle after accept). Without
// it rsp_err is always 0 and every address is issued unchanged.
module mem_access_unit
    import arc_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // main memory port
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out,
    // sequencer state for observation
    output logic [1:0]        dbg_state
);

    // Registered state
    state_e              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data_in;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    // Next-state values
    state_e              w_state_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_mem_address_nxt;
    logic [DATA_W-1:0]   w_mem_data_in_nxt;
    logic                w_mem_rd_nxt;
    logic                w_mem_wr_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                w_rsp_err_nxt;

    logic                w_misaligned;
    logic                w_accept;

`ifdef ALIGN_CHECK_EN
    mem_align_chk u_align_chk (
        .i_addr_lsb   (req_addr[ALIGN_BITS-1:0]),
        .o_misaligned (w_misaligned)
    );
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_accept = req_valid && (r_state == IDLE);

    // Next-state and next-output decode; every register holds unless told otherwise,
    // except the strobes, which default low so they never last beyond one cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_we_nxt          = r_we;
        w_mem_address_nxt = r_mem_address;
        w_mem_data_in_nxt = r_mem_data_in;
        w_mem_rd_nxt      = 1'b0;
        w_mem_wr_nxt      = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rsp_rdata_nxt = '0;
                    if (w_misaligned) begin
                        // Rejected access: no bus activity, error response next cycle.
                        w_rsp_err_nxt = 1'b1;
                        w_state_nxt   = RESP;
                    end else begin
                        // Launch the bus cycle so strobes and bus are valid in ISSUE.
                        w_rsp_err_nxt     = 1'b0;
                        w_we_nxt          = req_we;
                        w_mem_address_nxt = req_addr;
                        w_mem_data_in_nxt = req_wdata;
                        w_mem_rd_nxt      = ~req_we;
                        w_mem_wr_nxt      = req_we;
                        w_state_nxt       = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Memory registers read data on this edge; stores complete here.
                if (r_we) begin
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = RESP;
                end else begin
                    w_state_nxt     = CAPTURE;
                end
            end
            CAPTURE: begin
                w_rsp_rdata_nxt = mem_data_out;
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RST_STATE;
            r_we          <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_rd      <= RST_STROBE;
            r_mem_wr      <= RST_STROBE;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= RST_ERR;
        end else begin
            r_state       <= w_state_nxt;
            r_we          <= w_we_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_data_in <= w_mem_data_in_nxt;
            r_mem_rd      <= w_mem_rd_nxt;
            r_mem_wr      <= w_mem_wr_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic
// checked against a word-memory reference model with an expected-data queue.
// Honours ALIGN_CHECK_EN when the build defines it.
module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_data_out = '0;
    logic [1:0]    dbg_state;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .dbg_state    (dbg_state)
    );

    // ---------------- main memory model (registered read) ----------------
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (mem_wr) bus_mem[mem_address] = mem_data_in;
        if (mem_rd) mem_data_out <= bus_mem.exists(mem_address) ? bus_mem[mem_address] : '0;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int stall,
                             output logic [DW-1:0] rdata, output logic err, output int lat,
                             output int rd_n, output int wr_n,
                             output logic [AW-1:0] s_addr, output logic [DW-1:0] s_data,
                             output int acc_cyc, output bit stall_ok, output bit timeout);
        int guard;
        rd_n = 0; wr_n = 0; lat = 0; timeout = 0; stall_ok = 1; acc_cyc = 0;
        s_addr = '0; s_data = '0; rdata = '0; err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            timeout = 1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        // Scramble the request bus so the DUT must have latched its inputs.
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (mem_rd) begin rd_n++; s_addr = mem_address; end
            if (mem_wr) begin wr_n++; s_addr = mem_address; s_data = mem_data_in; end
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) begin
            timeout = 1;
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready || mem_rd || mem_wr)
                stall_ok = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd, mem_wr, mem_address, mem_data_in, dbg_state}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%0b vld=%0b rdata=%h err=%0b rd=%0b wr=%0b addr=%h din=%h st=%0d required rdy=1 others 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd, mem_wr, mem_address, mem_data_in, dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned_load();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        drive_txn(1'b0, 32'd2116, 32'h0, 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        checks++;
        if (to || lat != 3) begin errors++; $display("FAIL load_latency: got %0d (timeout=%0b) required 3", lat, to); end
        checks++;
        if (rn != 1 || wn != 0 || sa !== 32'd2116) begin
            errors++; $display("FAIL load_strobe: rd=%0d wr=%0d addr=%0d required rd=1 wr=0 addr=2116", rn, wn, sa);
        end
        checks++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            errors++; $display("FAIL load_data: rdata=%h err=%0b required 00000001 err=0", rd, er);
        end
    endtask

    task automatic test_store_then_load();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        drive_txn(1'b1, 32'd2088, 32'hD, 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        ref_mem[32'd2088] = 32'hD;
        checks++;
        if (to || lat != 2) begin errors++; $display("FAIL store_latency: got %0d (timeout=%0b) required 2", lat, to); end
        checks++;
        if (wn != 1 || rn != 0 || sa !== 32'd2088 || sd !== 32'hD) begin
            errors++; $display("FAIL store_strobe: wr=%0d rd=%0d addr=%0d data=%h required wr=1 rd=0 addr=2088 data=0000000d", wn, rn, sa, sd);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL store_rdata: rdata=%h err=%0b required 0 err=0", rd, er);
        end
        drive_txn(1'b0, 32'd2088, 32'h0, 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        checks++;
        if (to || rd !== ref_read(32'd2088)) begin
            errors++; $display("FAIL store_load_data: rdata=%h required %h", rd, ref_read(32'd2088));
        end
    endtask

    task automatic test_fetch();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        drive_txn(1'b0, 32'd2048, 32'h0, 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        checks++;
        if (to || rd !== 32'hC2002844) begin
            errors++; $display("FAIL fetch_data: rdata=%h required c2002844", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        drive_txn(1'b0, 32'd2116, 32'h0, 5, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        checks++;
        if (to || !ok) begin
            errors++; $display("FAIL backpressure_hold: stable=%0b timeout=%0b required stable=1", ok, to);
        end
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL backpressure_data: rdata=%h required 00000001", rd); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: rdy=%0b vld=%0b required rdy=1 vld=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd3000; req_wdata = 32'hA5A5_0001;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1) begin errors++; $display("FAIL reset_mid_issue: wr=%0b required 1", mem_wr); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_after: wr=%0b vld=%0b rdy=%0b required 0 0 1", mem_wr, rsp_valid, req_ready);
        end
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || mem_rd || mem_wr) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_quiet: activity cycles=%0d required 0", seen); end
    endtask

    task automatic test_misaligned();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        int exp_lat, exp_rn; logic exp_er; logic [DW-1:0] exp_rd;
        drive_txn(1'b0, 32'd2050, 32'h0, 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
        exp_lat = ALIGN_ON ? 1 : 3;
        exp_rn  = ALIGN_ON ? 0 : 1;
        exp_er  = ALIGN_ON;
        exp_rd  = ALIGN_ON ? '0 : ref_read(32'd2050);
        checks++;
        if (to || lat != exp_lat || rn != exp_rn || wn != 0) begin
            errors++; $display("FAIL misaligned_timing: lat=%0d rd=%0d wr=%0d required lat=%0d rd=%0d wr=0", lat, rn, wn, exp_lat, exp_rn);
        end
        checks++;
        if (er !== exp_er || rd !== exp_rd) begin
            errors++; $display("FAIL misaligned_rsp: err=%0b rdata=%h required err=%0b rdata=%h", er, rd, exp_er, exp_rd);
        end
        if (!ALIGN_ON) begin
            checks++;
            if (sa !== 32'd2050) begin errors++; $display("FAIL misaligned_addr: addr=%0d required 2050", sa); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac, prev_ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        logic prev_we;
        logic [5:0] pattern;
        pattern = 6'b111000;  // three loads then three stores (bit i = we of txn i)
        prev_ac = 0; prev_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_txn(pattern[i], 32'd2304 + 32'(4 * i), 32'h100 + 32'(i), 0, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
            if (pattern[i]) ref_mem[32'd2304 + 32'(4 * i)] = 32'h100 + 32'(i);
            if (i > 0) begin
                checks++;
                if (to || (ac - prev_ac) != (prev_we ? 3 : 4)) begin
                    errors++; $display("FAIL back_to_back_%0d: spacing=%0d required %0d", i, ac - prev_ac, prev_we ? 3 : 4);
                end
            end
            prev_ac = ac; prev_we = pattern[i];
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd; logic er; int lat, rn, wn, ac; logic [AW-1:0] sa; logic [DW-1:0] sd; bit ok, to;
        logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; int stall;
        logic mis; logic [DW-1:0] exp_rd; int exp_lat;
        for (int n = 0; n < 40; n++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 32'd2048 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            wd    = $urandom;
            stall = $urandom_range(0, 2);
            mis   = ALIGN_ON && (addr[1:0] != 2'b00);
            if (mis) begin
                exp_q.push_back('0); exp_lat = 1;
            end else if (we) begin
                ref_mem[addr] = wd; exp_q.push_back('0); exp_lat = 2;
            end else begin
                exp_q.push_back(ref_read(addr)); exp_lat = 3;
            end
            drive_txn(we, addr, wd, stall, rd, er, lat, rn, wn, sa, sd, ac, ok, to);
            exp_rd = exp_q.pop_front();
            checks++;
            if (to || rd !== exp_rd || er !== mis) begin
                errors++; $display("FAIL rand_%0d_rsp: rdata=%h err=%0b required %h err=%0b", n, rd, er, exp_rd, mis);
            end
            checks++;
            if (lat != exp_lat || !ok) begin
                errors++; $display("FAIL rand_%0d_timing: lat=%0d stable=%0b required lat=%0d stable=1", n, lat, ok, exp_lat);
            end
            checks++;
            if (mis ? (rn != 0 || wn != 0)
                    : (rn != int'(!we) || wn != int'(we) || sa !== addr || (we && sd !== wd))) begin
                errors++; $display("FAIL rand_%0d_bus: rd=%0d wr=%0d addr=%h data=%h required we=%0b addr=%h data=%h",
                                   n, rn, wn, sa, sd, we, addr, wd);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus_mem[32'd2116] = 32'h0000_0001;
        bus_mem[32'd2048] = 32'hC200_2844;
        ref_mem[32'd2116] = 32'h0000_0001;
        ref_mem[32'd2048] = 32'hC200_2844;

        test_reset();
        test_aligned_load();
        test_store_then_load();
        test_fetch();
        test_backpressure();
        test_reset_mid();
        test_misaligned();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bus initiator that drives the `main_memory` port (`address`, `data_in`, `rd`, `wr`, `data_out`) on behalf of the ARC control unit. The control unit submits one load, store or fetch at a time through a valid/ready request channel. The block sequences the memory strobes, captures the registered read data and returns a response with a valid/ready handshake. It sits between the control unit and main memory, with one transaction outstanding at a time.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- clk  in  1  rising-edge clock for all logic
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load/fetch
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_W  load data (0 for stores)
- rsp_err  out  1  misaligned access (see Configuration)
- mem_address  out  ADDR_W  to memory `address`
- mem_data_in  out  DATA_W  to memory `data_in`
- mem_rd  out  1  to memory `rd`
- mem_wr  out  1  to memory `wr`
- mem_data_out  in  DATA_W  from memory `data_out`, registered in memory on the rd edge

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:** req_ready=1. On req_valid, the block latches addr/we/wdata and goes to ISSUE. Under an alignment error it goes straight to RESP instead.
- **ISSUE:** exactly one cycle, with mem_rd=!we, mem_wr=we and mem_address/mem_data_in driven from the latched values.
  - Load: next state is CAPTURE.
  - Store: next state is RESP with rsp_rdata=0.
- **CAPTURE:** strobes are low. mem_data_out is sampled into rsp_rdata, and the state goes to RESP.
- **RESP:** rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready is sampled high, then the state returns to IDLE.
- req_ready=0 in every state except IDLE, so a request arriving while busy stalls and is not dropped.
- mem_rd and mem_wr are registered, mutually exclusive, and high for at most one cycle per transaction.
- mem_address and mem_data_in hold their last value outside ISSUE. No bus glitch is produced.
- Addresses are passed to memory unchanged. No address translation is performed.

## Timing
- **Reset values:** state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rd=0, mem_wr=0, mem_address=0, mem_data_in=0.
- **Load:** accept at edge N → mem_rd high in cycle N+1 → data captured at edge N+2 → rsp_valid high in cycle N+3. Accept-to-response is 3 cycles.
- **Store:** accept at edge N → mem_wr high in cycle N+1 → rsp_valid high in cycle N+2. Accept-to-response is 2 cycles.
- **Back-to-back:** with rsp_ready held high, the next request is accepted in the cycle after RESP completes. A load takes 4 cycles per transaction; a store takes 3.
- **Reset mid-transaction:** the next edge returns all outputs to reset values. A strobe already high is low in the following cycle, and the pending transaction is discarded with no response.
- **Response stall:** rsp_ready low in RESP holds indefinitely with no new memory activity.

## Configuration
- **ALIGN_CHECK_EN defined:** req_addr[1:0]≠0 at acceptance produces no memory strobe. The FSM goes IDLE→RESP (rsp_valid one cycle after accept) with rsp_err=1 and rsp_rdata=0.
- **ALIGN_CHECK_EN undefined:** rsp_err is tied 0 and every address is issued unchanged.

## Structure
- **Package arc_mem_pkg:** ADDR_W/DATA_W defaults, WORD_BYTES=4, the state enum (IDLE, ISSUE, CAPTURE, RESP), and the reset constants.
- **Sub-module mem_align_chk:** combinational alignment check on req_addr. It is instantiated only under ALIGN_CHECK_EN.

## Test plan
- **Aligned load:** memory preloaded with 0x00000001 at 2116; load from 2116 → mem_rd one cycle at 2116, rsp_valid 3 cycles after accept, rsp_rdata=0x00000001, rsp_err=0.
- **Store then load:** store 0x0000000D to 2088, then load 2088 → mem_wr one cycle with data 0x0000000D, store rsp_valid after 2 cycles, load returns 0x0000000D.
- **Instruction fetch:** load from 2048 → rsp_rdata=0xC2002844.
- **Response backpressure:** rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, no strobes; rsp_ready high → IDLE next cycle.
- **Reset during ISSUE:** rst high during a store's ISSUE cycle → mem_wr=0 next cycle, no rsp_valid, req_ready=1.
- **Misaligned load (ALIGN_CHECK_EN):** load from 2050 → no mem_rd, rsp_valid one cycle after accept, rsp_err=1, rsp_rdata=0. Without the macro → mem_rd issued at 2050, rsp_err=0.
